// File: rtl/dwc_pkg.sv
// Shared types and helpers for the DwC error monitor: FSM state encoding,
// run-counter width and a saturating increment.
package dwc_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } dwc_state_e;

  localparam int RUN_W = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dwc_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module dwc_sat_counter
  import dwc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_next;

  assign w_next = W'(sat_inc(32'(r_cnt), 32'(MAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= w_next;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dwc_error_monitor.sv
// Persistence filter behind a DwC stage: sticky fault alarm, saturating mismatch
// count, 1-cycle data forwarding. DWC_MON_HOLD_EN: hold data_out on last clean sample.
module dwc_error_monitor
  import dwc_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 8,
  parameter int THRESH  = 3,
  parameter int RECOVER = 4,
  parameter int ERR_POL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] port_data_in,
  input  logic             port_error_in,
  input  logic             port_valid_in,
  input  logic             port_clear,
  output logic [WIDTH-1:0] port_data_out,
  output logic             port_valid_out,
  output logic             port_fault,
  output logic [CNT_W-1:0] port_err_count,
  output logic [1:0]       port_state
);

  if (THRESH < 1 || THRESH > 15) begin : g_bad_thresh
    $error("dwc_error_monitor: THRESH must be in 1..15");
  end
  if (RECOVER < 1 || RECOVER > 15) begin : g_bad_recover
    $error("dwc_error_monitor: RECOVER must be in 1..15");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cntw
    $error("dwc_error_monitor: CNT_W must be in 1..32");
  end

  localparam logic ERR_LVL = (ERR_POL != 0);

  dwc_state_e       r_state, w_state_nxt;
  logic             r_fault;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [RUN_W-1:0] w_bad, w_good;
  logic             w_mis, w_clean, w_active;
  logic             w_bad_hit, w_good_hit, w_to_ok;

  assign w_mis    = port_valid_in && (port_error_in == ERR_LVL);
  assign w_clean  = port_valid_in && !w_mis;
  assign w_active = (r_state != ST_FAULT);

  // Compare against the count this sample would produce, so the transition
  // fires on the THRESH-th / RECOVER-th sample itself.
  assign w_bad_hit  = ({1'b0, w_bad}  + 5'd1) >= 5'(THRESH);
  assign w_good_hit = ({1'b0, w_good} + 5'd1) >= 5'(RECOVER);

  always_comb begin
    w_state_nxt = r_state;
    w_to_ok     = 1'b0;
    unique case (r_state)
      ST_OK: begin
        if (w_mis) w_state_nxt = w_bad_hit ? ST_FAULT : ST_SUSPECT;
      end
      ST_SUSPECT: begin
        if (w_mis) begin
          if (w_bad_hit) w_state_nxt = ST_FAULT;
        end else if (w_clean && w_good_hit) begin
          w_state_nxt = ST_OK;
          w_to_ok     = 1'b1;
        end
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_OK;
    endcase
    if (port_clear) w_state_nxt = ST_OK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OK;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= (w_state_nxt == ST_FAULT);
    end
  end

  dwc_sat_counter #(.W(RUN_W)) u_run_bad (
    .clk   (clk),
    .rst   (rst),
    .i_clr (port_clear || (w_clean && w_active)),
    .i_inc (w_mis && w_active),
    .o_cnt (w_bad)
  );

  dwc_sat_counter #(.W(RUN_W)) u_run_good (
    .clk   (clk),
    .rst   (rst),
    .i_clr (port_clear || (w_mis && w_active) || w_to_ok),
    .i_inc (w_clean && (r_state == ST_SUSPECT)),
    .o_cnt (w_good)
  );

  dwc_sat_counter #(.W(CNT_W)) u_err_total (
    .clk   (clk),
    .rst   (rst),
    .i_clr (port_clear),
    .i_inc (w_mis),
    .o_cnt (port_err_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= port_valid_in;
`ifdef DWC_MON_HOLD_EN
      if (w_clean && w_active) r_data <= port_data_in;
`else
      r_data <= port_data_in;
`endif
    end
  end

  assign port_data_out  = r_data;
  assign port_valid_out = r_valid;
  assign port_fault     = r_fault;
  assign port_state     = r_state;

endmodule
